// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
// rob_entry_t is one ROB slot; reg_stat_t is the register-status record
// that holds the producer tag for each architectural register.
package reorder_buffer_pkg;

  localparam int ROB_TAG_W  = 4;
  localparam int ROB_DEPTH  = (1 << ROB_TAG_W) - 1;  // tag 0 means "no producer"
  localparam int ROB_XLEN   = 32;                    // width of the stored result
  localparam int ROB_ARCH_W = 5;                     // architectural register index

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  writes;
    logic                  is_store;
    logic                  is_branch;
    logic                  mispredict;
    logic [ROB_ARCH_W-1:0] dest;
    logic [ROB_XLEN-1:0]   value;
  } rob_entry_t;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
  } reg_stat_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / operand-lookup / commit bundle of the reorder buffer.
// slave = the ROB itself, master = the surrounding pipeline.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int XLEN  = ROB_XLEN,
  parameter int TAG_W = ROB_TAG_W
);
  logic                  issue_valid;
  logic                  issue_writes;
  logic                  issue_is_store;
  logic                  issue_is_branch;
  logic [ROB_ARCH_W-1:0] issue_dest;
  logic                  issue_ready;
  logic [TAG_W-1:0]      issue_ROB;

  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_ROB;
  logic [XLEN-1:0]       cdb_value;
  logic                  cdb_mispredict;

  logic [TAG_W-1:0]      Q_j;
  logic [TAG_W-1:0]      Q_k;
  logic                  j_ready;
  logic                  k_ready;
  logic [XLEN-1:0]       j_value;
  logic [XLEN-1:0]       k_value;

  logic                  mem_ready;
  logic                  commit_valid;
  logic [TAG_W-1:0]      commit_ROB;
  logic [ROB_ARCH_W-1:0] commit_dest;
  logic [XLEN-1:0]       commit_value;
  logic                  RegWrite;
  logic                  commit_store;
  logic                  flush;
  logic [TAG_W-1:0]      count;

  modport slave (
    input  issue_valid, issue_writes, issue_is_store, issue_is_branch, issue_dest,
    output issue_ready, issue_ROB,
    input  cdb_valid, cdb_ROB, cdb_value, cdb_mispredict,
    input  Q_j, Q_k,
    output j_ready, k_ready, j_value, k_value,
    input  mem_ready,
    output commit_valid, commit_ROB, commit_dest, commit_value, RegWrite, commit_store,
    output flush, count
  );

  modport master (
    output issue_valid, issue_writes, issue_is_store, issue_is_branch, issue_dest,
    input  issue_ready, issue_ROB,
    output cdb_valid, cdb_ROB, cdb_value, cdb_mispredict,
    output Q_j, Q_k,
    input  j_ready, k_ready, j_value, k_value,
    output mem_ready,
    input  commit_valid, commit_ROB, commit_dest, commit_value, RegWrite, commit_store,
    input  flush, count
  );
endinterface

// File: rtl/reorder_buffer_tag_counter.sv
// Circular ROB tag pointer: counts 1..2^TAG_W-1 and wraps back to 1,
// never producing the reserved tag 0. Used for both head and tail.
module rob_tag_counter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active-low
  input  logic             clear,   // return to the first tag (flush)
  input  logic             inc,
  output logic [TAG_W-1:0] value
);
  localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST  = '1;

  // Pointer register: reset/clear to tag 1, advance with wrap past the last tag.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      value <= FIRST;
    end else if (inc) begin
      value <= (value == LAST) ? FIRST : value + TAG_W'(1);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: 2^TAG_W-1 entries indexed by tag, in-order commit from
// head, CDB result capture, combinational operand lookup, and a one-cycle
// flush when a mispredicted branch commits.
// Optional feature: define ROB_CDB_BYPASS_EN to forward a same-cycle CDB
// broadcast straight into the operand lookup.
// XLEN must equal ROB_XLEN, which sizes the value field of rob_entry_t.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int XLEN  = ROB_XLEN,
  parameter int TAG_W = ROB_TAG_W
) (
  input logic             clk,
  input logic             reset,   // synchronous, active-low
  reorder_buffer_if.slave bus
);
  localparam int DEPTH = (1 << TAG_W) - 1;

  rob_entry_t       entries [0:DEPTH];  // slot 0 is never written
  rob_entry_t       head_e;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] count_q;
  logic             commit_ok;
  logic             flush_now;
  logic             issue_fire;
  logic             cdb_hit;

  rob_tag_counter #(.TAG_W(TAG_W)) u_head (
    .clk(clk), .reset(reset), .clear(flush_now), .inc(commit_ok), .value(head)
  );

  rob_tag_counter #(.TAG_W(TAG_W)) u_tail (
    .clk(clk), .reset(reset), .clear(flush_now), .inc(issue_fire), .value(tail)
  );

  assign head_e = entries[head];

  // Control decode: commit eligibility, flush, issue acceptance, CDB match.
  always_comb begin
    commit_ok  = reset && (count_q != '0) && head_e.done
                 && (!head_e.is_store || bus.mem_ready);
    flush_now  = commit_ok && head_e.is_branch && head_e.mispredict;
    issue_fire = reset && bus.issue_valid && (count_q < TAG_W'(DEPTH)) && !flush_now;
    cdb_hit    = bus.cdb_valid && (bus.cdb_ROB != '0) && entries[bus.cdb_ROB].busy;
  end

  // Issue and commit ports; commit fields read zero whenever nothing commits.
  always_comb begin
    bus.issue_ready  = !reset || ((count_q < TAG_W'(DEPTH)) && !flush_now);
    bus.issue_ROB    = reset ? tail : TAG_W'(1);
    bus.commit_valid = commit_ok;
    bus.commit_ROB   = commit_ok ? head : '0;
    bus.commit_dest  = commit_ok ? head_e.dest : '0;
    bus.commit_value = commit_ok ? XLEN'(head_e.value) : '0;
    bus.RegWrite     = commit_ok && head_e.writes && (head_e.dest != '0);
    bus.commit_store = commit_ok && head_e.is_store;
    bus.flush        = flush_now;
    bus.count        = count_q;
  end

  // Operand lookup by producer tag, with optional same-cycle CDB forwarding.
  always_comb begin
    bus.j_ready = 1'b0;
    bus.j_value = '0;
    bus.k_ready = 1'b0;
    bus.k_value = '0;
    if (bus.Q_j != '0) begin
      bus.j_ready = entries[bus.Q_j].done;
      bus.j_value = XLEN'(entries[bus.Q_j].value);
    end
    if (bus.Q_k != '0) begin
      bus.k_ready = entries[bus.Q_k].done;
      bus.k_value = XLEN'(entries[bus.Q_k].value);
    end
`ifdef ROB_CDB_BYPASS_EN
    if (bus.cdb_valid && (bus.cdb_ROB == bus.Q_j) && (bus.Q_j != '0)) begin
      bus.j_ready = 1'b1;
      bus.j_value = bus.cdb_value;
    end
    if (bus.cdb_valid && (bus.cdb_ROB == bus.Q_k) && (bus.Q_k != '0)) begin
      bus.k_ready = 1'b1;
      bus.k_value = bus.cdb_value;
    end
`else
    // Results become visible one cycle after the broadcast, via the entry.
`endif
    if (!reset) begin
      bus.j_ready = 1'b0;
      bus.j_value = '0;
      bus.k_ready = 1'b0;
      bus.k_value = '0;
    end
  end

  // Entry array and occupancy: CDB capture, commit release, issue allocate.
  always_ff @(posedge clk) begin
    if (!reset || flush_now) begin
      // NOTE: the entry array is reset on purpose -- busy/done must be clean
      // after reset or flush, otherwise stale entries could commit or answer
      // operand lookups.
      for (int i = 0; i <= DEPTH; i++) begin
        entries[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (cdb_hit) begin
        entries[bus.cdb_ROB].done       <= 1'b1;
        entries[bus.cdb_ROB].value      <= ROB_XLEN'(bus.cdb_value);
        entries[bus.cdb_ROB].mispredict <= bus.cdb_mispredict;
      end
      if (commit_ok) begin
        entries[head].busy <= 1'b0;
        entries[head].done <= 1'b0;
      end
      if (issue_fire) begin
        entries[tail] <= '{busy:       1'b1,
                           done:       1'b0,
                           writes:     bus.issue_writes,
                           is_store:   bus.issue_is_store,
                           is_branch:  bus.issue_is_branch,
                           mispredict: 1'b0,
                           dest:       bus.issue_dest,
                           value:      '0};
      end
      count_q <= count_q + TAG_W'(issue_fire) - TAG_W'(commit_ok);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: issue pushes the expected commit,
// an independent monitor pops and compares on every commit_valid.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  reorder_buffer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [4:0]       dest;
    logic [XLEN-1:0]  value;
    logic             regwrite;
    logic             store;
    logic             flush;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic s, input logic b, input logic [4:0] dest,
                       input logic [XLEN-1:0] val, input int exp_tag, input bit keep,
                       input bit exp_flush);
    bus.issue_valid     = 1'b1;
    bus.issue_writes    = w;
    bus.issue_is_store  = s;
    bus.issue_is_branch = b;
    bus.issue_dest      = dest;
    @(negedge clk);
    check("issue_ready", bus.issue_ready, 1);
    check("issue_tag", bus.issue_ROB, exp_tag);
    if (keep)
      exp_q.push_back('{tag: TAG_W'(exp_tag), dest: dest, value: val,
                        regwrite: w && (dest != 0), store: s, flush: exp_flush});
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic cdb(input int tag, input logic [XLEN-1:0] val, input logic mp);
    bus.cdb_valid      = 1'b1;
    bus.cdb_ROB        = TAG_W'(tag);
    bus.cdb_value      = val;
    bus.cdb_mispredict = mp;
    tick();
    bus.cdb_valid      = 1'b0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic wait_count(input string name, input int target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.count == TAG_W'(target)) hit = 1'b1;
    end
    check(name, bus.count, target);
    tick();
  endtask

  // Monitor: every presented commit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.commit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got tag %0h expected no commit at %0t",
                 bus.commit_ROB, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_tag", bus.commit_ROB, mon_e.tag);
        check("commit_dest", bus.commit_dest, mon_e.dest);
        check("commit_value", bus.commit_value, mon_e.value);
        check("commit_regwrite", bus.RegWrite, mon_e.regwrite);
        check("commit_store", bus.commit_store, mon_e.store);
        check("commit_flush", bus.flush, mon_e.flush);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.issue_valid = 0; bus.issue_writes = 0; bus.issue_is_store = 0;
    bus.issue_is_branch = 0; bus.issue_dest = 0;
    bus.cdb_valid = 0; bus.cdb_ROB = 0; bus.cdb_value = 0; bus.cdb_mispredict = 0;
    bus.Q_j = 0; bus.Q_k = 0; bus.mem_ready = 0;

    // Reset: outputs idle during and after reset.
    tick();
    @(negedge clk);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_issue_ready", bus.issue_ready, 1);
    check("rst_issue_tag", bus.issue_ROB, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_issue_tag_after", bus.issue_ROB, 1);
    check("rst_flush", bus.flush, 0);
    check("rst_j_ready", bus.j_ready, 0);
    tick();

    // Fill all 15 entries with writes to x5; tag 2 will carry 0xDEAD.
    for (int t = 1; t <= ROB_DEPTH; t++)
      issue(1, 0, 0, 5'd5, (t == 2) ? 32'hDEAD : 32'h100 + t, t, 1, 0);
    @(negedge clk);
    check("full_count", bus.count, 15);
    check("full_issue_ready", bus.issue_ready, 0);
    check("full_tail_wrap", bus.issue_ROB, 1);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_writes = 1'b1;
    bus.issue_dest = 5'd5;
    @(negedge clk);
    check("issue16_ready", bus.issue_ready, 0);
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("issue16_count", bus.count, 15);
    tick();

    // Out-of-order completion: tag 2 done first must not commit.
    cdb(2, 32'hDEAD, 0);
    @(negedge clk);
    check("no_commit_before_head", bus.commit_valid, 0);
    tick();
    cdb(1, 32'h101, 0);
    wait_count("after_two_commits", 13, 10);

    // Tag 1 has committed; the next allocation wraps to tag 1, dest x0.
    issue(1, 0, 0, 5'd0, 32'h77, 1, 1, 0);
    for (int t = 3; t <= ROB_DEPTH; t++) cdb(t, 32'h100 + t, 0);
    cdb(1, 32'h77, 0);
    wait_count("drain_after_wrap", 0, 40);

    // Store held at head while memory is busy.
    issue(0, 1, 0, 5'd0, 32'h5, 2, 1, 0);
    cdb(2, 32'h5, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("store_wait_mem", bus.commit_valid, 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("store_commit", bus.commit_store, 1);
    tick();
    bus.mem_ready = 1'b0;
    wait_count("store_drain", 0, 5);

    // Mispredicted branch at tag 3 with younger tags 4..6 in flight.
    issue(0, 0, 1, 5'd0, 32'h33, 3, 1, 1);
    for (int t = 4; t <= 6; t++) issue(1, 0, 0, 5'd7, 32'h0, t, 0, 0);
    cdb(3, 32'h33, 1);
    bus.issue_valid = 1'b1;
    bus.issue_writes = 1'b1;
    bus.issue_dest = 5'd9;
    bus.cdb_valid = 1'b1;
    bus.cdb_ROB = 4'd4;
    bus.cdb_value = 32'h4;
    @(negedge clk);
    check("flush_pulse", bus.flush, 1);
    check("flush_issue_ready", bus.issue_ready, 0);
    tick();
    bus.issue_valid = 1'b0;
    bus.cdb_valid = 1'b0;
    @(negedge clk);
    check("post_flush_count", bus.count, 0);
    check("post_flush_tail", bus.issue_ROB, 1);
    check("post_flush_flush", bus.flush, 0);
    check("post_flush_commit", bus.commit_valid, 0);
    tick();
    issue(1, 0, 0, 5'd8, 32'h88, 1, 1, 0);
    cdb(1, 32'h88, 0);
    wait_count("post_flush_drain", 0, 5);

    // Operand lookup against tag 4 broadcast in the same cycle.
    issue(1, 0, 0, 5'd10, 32'h22, 2, 1, 0);
    issue(1, 0, 0, 5'd11, 32'h33, 3, 1, 0);
    issue(1, 0, 0, 5'd12, 32'h44, 4, 1, 0);
    bus.Q_j = 4'd4;
    bus.Q_k = 4'd3;
    bus.cdb_valid = 1'b1;
    bus.cdb_ROB = 4'd4;
    bus.cdb_value = 32'h44;
    @(negedge clk);
    check("j_ready_same_cycle", bus.j_ready, BYPASS);
    check("k_ready_pending", bus.k_ready, 0);
    tick();
    bus.cdb_valid = 1'b0;
    @(negedge clk);
    check("j_ready_next", bus.j_ready, 1);
    check("j_value_next", bus.j_value, 32'h44);
    tick();
    bus.Q_j = 4'd0;
    bus.Q_k = 4'd0;
    @(negedge clk);
    check("j_ready_tag0", bus.j_ready, 0);
    check("k_value_tag0", bus.k_value, 0);
    tick();
    cdb(2, 32'h22, 0);
    cdb(3, 32'h33, 0);
    wait_count("lookup_drain", 0, 10);

    // Reset with a committable head: nothing may commit.
    issue(1, 0, 0, 5'd13, 32'h55, 5, 0, 0);
    issue(1, 0, 0, 5'd14, 32'h66, 6, 0, 0);
    cdb(5, 32'h55, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_commit_valid", bus.commit_valid, 0);
    check("midrst_regwrite", bus.RegWrite, 0);
    check("midrst_issue_tag", bus.issue_ROB, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_count", bus.count, 0);
    tick();
    issue(1, 0, 0, 5'd3, 32'h31, 1, 1, 0);
    cdb(1, 32'h31, 0);
    wait_count("midrst_drain", 0, 5);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
